// File: rtl/consola_pantalla.sv
// Text-console sequencer for the pantalla write port: cursor tracking, control codes, paced glyph writes.
// Optional build macro CONSOLA_CLR_LINE_EN blanks each row as the cursor enters it.
module consola_pantalla #(
  parameter int COLS      = 21,
  parameter int ROWS      = 8,
  parameter int CHAR_W    = 6,
  parameter int CHAR_H    = 8,
  parameter int WR_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       busy,
  output logic       wr,
  output logic [6:0] posx,
  output logic [5:0] posy,
  output logic [6:0] caracter,
  output logic [4:0] cur_col,
  output logic [2:0] cur_row
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [6:0] SPACE    = 7'h20;

  logic [2:0]       state_reg;
  logic [7:0]       byte_reg;
  logic [4:0]       clr_col_reg;
  logic [2:0]       clr_row_reg;
  logic             clr_act_reg;
  logic             clr_full_reg;
  logic             adv_pend_reg;
  logic             line_pend_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  logic [4:0] adv_col_next;
  logic [2:0] adv_row_next;
  logic       adv_wrap_next;
  logic [2:0] lf_row_next;

  assign char_ready = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign wr         = (state_reg == S_WRITE);

  // Cursor position after a printed glyph and after a line feed.
  always_comb begin
    adv_col_next  = cur_col + 5'd1;
    adv_row_next  = cur_row;
    adv_wrap_next = 1'b0;
    lf_row_next   = (cur_row == LAST_ROW) ? 3'd0 : cur_row + 3'd1;
    if (cur_col == LAST_COL) begin
      adv_col_next  = 5'd0;
      adv_row_next  = lf_row_next;
      adv_wrap_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_CLEAR;
      byte_reg      <= 8'h00;
      posx          <= 7'd0;
      posy          <= 6'd0;
      caracter      <= SPACE;
      cur_col       <= 5'd0;
      cur_row       <= 3'd0;
      clr_col_reg   <= 5'd0;
      clr_row_reg   <= 3'd0;
      clr_act_reg   <= 1'b0;
      clr_full_reg  <= 1'b1;
      adv_pend_reg  <= 1'b0;
      line_pend_reg <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        S_CLEAR: begin
          posx        <= 7'(clr_col_reg * CHAR_W);
          posy        <= 6'(clr_row_reg * CHAR_H);
          caracter    <= SPACE;
          clr_act_reg <= 1'b1;
          state_reg   <= S_WRITE;
        end
        S_IDLE: begin
          if (char_valid) begin
            byte_reg  <= char_in;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_reg    <= S_IDLE;
          clr_act_reg  <= 1'b0;
          adv_pend_reg <= 1'b0;
          if (byte_reg >= 8'h20 && byte_reg != 8'h7F) begin
            // Non-ASCII bytes show as '?'
            caracter     <= (byte_reg >= 8'h80) ? 7'h3F : byte_reg[6:0];
            posx         <= 7'(cur_col * CHAR_W);
            posy         <= 6'(cur_row * CHAR_H);
            adv_pend_reg <= 1'b1;
            state_reg    <= S_WRITE;
          end else begin
            case (byte_reg)
              8'h0A: begin
                cur_col <= 5'd0;
                cur_row <= lf_row_next;
`ifdef CONSOLA_CLR_LINE_EN
                clr_col_reg  <= 5'd0;
                clr_row_reg  <= lf_row_next;
                clr_full_reg <= 1'b0;
                state_reg    <= S_CLEAR;
`endif
              end
              8'h0D: cur_col <= 5'd0;
              8'h08: begin
                if (cur_col != 5'd0) begin
                  cur_col   <= cur_col - 5'd1;
                  posx      <= 7'((cur_col - 5'd1) * CHAR_W);
                  posy      <= 6'(cur_row * CHAR_H);
                  caracter  <= SPACE;
                  state_reg <= S_WRITE;
                end
              end
              8'h0C: begin
                cur_col      <= 5'd0;
                cur_row      <= 3'd0;
                clr_col_reg  <= 5'd0;
                clr_row_reg  <= 3'd0;
                clr_full_reg <= 1'b1;
                state_reg    <= S_CLEAR;
              end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          wait_cnt_reg <= CNT_W'(WR_CYCLES - 1);
          state_reg    <= S_WAIT;
          if (adv_pend_reg) begin
            adv_pend_reg <= 1'b0;
            cur_col      <= adv_col_next;
            cur_row      <= adv_row_next;
`ifdef CONSOLA_CLR_LINE_EN
            if (adv_wrap_next) begin
              line_pend_reg <= 1'b1;
              clr_col_reg   <= 5'd0;
              clr_row_reg   <= adv_row_next;
              clr_full_reg  <= 1'b0;
            end
`endif
          end
        end
        S_WAIT: begin
          if (wait_cnt_reg != '0) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end else if (clr_act_reg) begin
            // A line clear ends at the row's last cell, a full clear at the last row.
            if (clr_col_reg == LAST_COL && (!clr_full_reg || clr_row_reg == LAST_ROW)) begin
              clr_act_reg <= 1'b0;
              state_reg   <= S_IDLE;
              if (clr_full_reg) begin
                cur_col <= 5'd0;
                cur_row <= 3'd0;
              end
            end else begin
              if (clr_col_reg == LAST_COL) begin
                clr_col_reg <= 5'd0;
                clr_row_reg <= clr_row_reg + 3'd1;
              end else begin
                clr_col_reg <= clr_col_reg + 5'd1;
              end
              state_reg <= S_CLEAR;
            end
          end else if (line_pend_reg) begin
            line_pend_reg <= 1'b0;
            state_reg     <= S_CLEAR;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_CLEAR;
      endcase
    end
  end

  logic unused_adv;
  assign unused_adv = adv_wrap_next;

endmodule

// File: tb/tb_consola_pantalla.sv
// Directed bench for consola_pantalla: logs every wr pulse and checks it against hand-computed cells.
module tb_consola_pantalla;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, busy, wr;
  logic [6:0] posx, caracter;
  logic [5:0] posy;
  logic [4:0] cur_col;
  logic [2:0] cur_row;

  consola_pantalla dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .wr(wr), .posx(posx), .posy(posy),
    .caracter(caracter), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each entry is {posx, posy, caracter} of one wr pulse.
  logic [19:0] wq[$];
  always @(negedge clk) if (wr === 1'b1) wq.push_back({posx, posy, caracter});

  task automatic wait_ready(input int budget);
    int n = 0;
    while (char_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (char_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL ready_timeout: char_ready=%b after %0d cycles, required 1", char_ready, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int lat, output int pre);
    int c0;
    wait_ready(5000);
    pre = wq.size();
    c0 = cyc;
    char_in = b;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    wait_ready(5000);
    lat = cyc - c0;
  endtask

  function automatic int clear_errors();
    int e = 0;
    if (wq.size() != 168) e++;
    for (int i = 0; i < wq.size() && i < 168; i++)
      if (wq[i] !== {7'((i % 21) * 6), 6'((i / 21) * 8), 7'h20}) e++;
    return e;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL rst_wr: got %b want 0", wr); end
    tests++; if (posx !== 7'd0) begin fails++; $display("FAIL rst_posx: got %0d want 0", posx); end
    tests++; if (posy !== 6'd0) begin fails++; $display("FAIL rst_posy: got %0d want 0", posy); end
    tests++; if (caracter !== 7'h20) begin fails++; $display("FAIL rst_caracter: got %h want 20", caracter); end
    tests++; if (cur_col !== 5'd0 || cur_row !== 3'd0) begin fails++; $display("FAIL rst_cursor: got %0d,%0d want 0,0", cur_col, cur_row); end
    tests++; if (char_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", char_ready); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", busy); end
    wq.delete();
    rst = 1'b0;
    wait_ready(5000);
    tests++; if (wq.size() != 168) begin fails++; $display("FAIL init_clear_count: got %0d want 168", wq.size()); end
    tests++; if (clear_errors() != 0) begin fails++; $display("FAIL init_clear_cells: %0d bad entries, want 0", clear_errors()); end
    tests++; if (wq.size() > 0 && wq[wq.size()-1] !== {7'd120, 6'd56, 7'h20}) begin fails++; $display("FAIL init_clear_last: got %h want %h", wq[wq.size()-1], {7'd120, 6'd56, 7'h20}); end
    tests++; if (cur_col !== 5'd0 || cur_row !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL init_done: cursor %0d,%0d busy %b want 0,0 busy 0", cur_col, cur_row, busy); end
  endtask

  task automatic test_print;
    int lat, pre;
    send_byte(8'h41, lat, pre);
    tests++; if (wq.size() != pre + 1 || wq[pre] !== {7'd0, 6'd0, 7'h41}) begin fails++; $display("FAIL print_A: got %h (n=%0d) want %h", wq[pre], wq.size() - pre, {7'd0, 6'd0, 7'h41}); end
    tests++; if (lat != 19) begin fails++; $display("FAIL print_A_latency: got %0d want 19", lat); end
    send_byte(8'h42, lat, pre);
    tests++; if (wq.size() != pre + 1 || wq[pre] !== {7'd6, 6'd0, 7'h42}) begin fails++; $display("FAIL print_B: got %h want %h", wq[pre], {7'd6, 6'd0, 7'h42}); end
    tests++; if (lat != 19) begin fails++; $display("FAIL print_B_latency: got %0d want 19", lat); end
    tests++; if (cur_col !== 5'd2 || cur_row !== 3'd0) begin fails++; $display("FAIL print_cursor: got %0d,%0d want 2,0", cur_col, cur_row); end
  endtask

  task automatic test_row_wrap;
    int lat, pre;
    for (int i = 2; i < 21; i++) begin
      send_byte(8'h50, lat, pre);
      if (i == 20) begin
        tests++; if (wq[pre] !== {7'd120, 6'd0, 7'h50}) begin fails++; $display("FAIL wrap_last_col: got %h want %h", wq[pre], {7'd120, 6'd0, 7'h50}); end
      end
    end
    tests++; if (cur_col !== 5'd0 || cur_row !== 3'd1) begin fails++; $display("FAIL wrap_cursor: got %0d,%0d want 0,1", cur_col, cur_row); end
    send_byte(8'h43, lat, pre);
    tests++; if (wq[pre] !== {7'd0, 6'd8, 7'h43}) begin fails++; $display("FAIL wrap_next_row: got %h want %h", wq[pre], {7'd0, 6'd8, 7'h43}); end
    tests++; if (cur_col !== 5'd1 || cur_row !== 3'd1) begin fails++; $display("FAIL wrap_cursor2: got %0d,%0d want 1,1", cur_col, cur_row); end
  endtask

  task automatic test_line_feed;
    int lat, pre, bad;
    send_byte(8'h0D, lat, pre);
    tests++; if (cur_col !== 5'd0 || lat != 2) begin fails++; $display("FAIL cr: col %0d lat %0d want 0 lat 2", cur_col, lat); end
    for (int i = 0; i < 6; i++) send_byte(8'h0A, lat, pre);
    tests++; if (cur_row !== 3'd7 || cur_col !== 5'd0) begin fails++; $display("FAIL lf_to_row7: got %0d,%0d want 0,7", cur_col, cur_row); end
    send_byte(8'h0A, lat, pre);
    tests++; if (cur_row !== 3'd0 || cur_col !== 5'd0) begin fails++; $display("FAIL lf_wrap: got %0d,%0d want 0,0", cur_col, cur_row); end
`ifdef CONSOLA_CLR_LINE_EN
    bad = 0;
    for (int i = 0; i < 21; i++)
      if (pre + i >= wq.size() || wq[pre+i] !== {7'(i * 6), 6'd0, 7'h20}) bad++;
    tests++; if (wq.size() != pre + 21 || bad != 0) begin fails++; $display("FAIL lf_line_clear: %0d writes %0d bad, want 21 writes 0 bad", wq.size() - pre, bad); end
`else
    bad = wq.size() - pre;
    tests++; if (bad != 0) begin fails++; $display("FAIL lf_no_write: got %0d writes want 0", bad); end
    tests++; if (lat != 2) begin fails++; $display("FAIL lf_latency: got %0d want 2", lat); end
`endif
  endtask

  task automatic test_backspace;
    int lat, pre;
    send_byte(8'h61, lat, pre);
    send_byte(8'h62, lat, pre);
    send_byte(8'h63, lat, pre);
    tests++; if (cur_col !== 5'd3) begin fails++; $display("FAIL bs_setup: got col %0d want 3", cur_col); end
    send_byte(8'h08, lat, pre);
    tests++; if (wq.size() != pre + 1 || wq[pre] !== {7'd12, 6'd0, 7'h20}) begin fails++; $display("FAIL bs_write: got %h want %h", wq[pre], {7'd12, 6'd0, 7'h20}); end
    tests++; if (cur_col !== 5'd2) begin fails++; $display("FAIL bs_cursor: got %0d want 2", cur_col); end
    send_byte(8'h0D, lat, pre);
    send_byte(8'h08, lat, pre);
    tests++; if (wq.size() != pre || cur_col !== 5'd0) begin fails++; $display("FAIL bs_col0: writes %0d col %0d want 0 writes col 0", wq.size() - pre, cur_col); end
  endtask

  task automatic test_codes;
    int lat, pre;
    send_byte(8'hC5, lat, pre);
    tests++; if (wq.size() != pre + 1 || wq[pre] !== {7'd0, 6'd0, 7'h3F}) begin fails++; $display("FAIL high_byte: got %h want %h", wq[pre], {7'd0, 6'd0, 7'h3F}); end
    send_byte(8'h07, lat, pre);
    tests++; if (wq.size() != pre || cur_col !== 5'd1 || lat != 2) begin fails++; $display("FAIL bell_ignored: writes %0d col %0d lat %0d want 0 col 1 lat 2", wq.size() - pre, cur_col, lat); end
  endtask

  task automatic test_form_feed;
    int lat, pre;
    wait_ready(5000);
    wq.delete();
    send_byte(8'h0C, lat, pre);
    tests++; if (clear_errors() != 0) begin fails++; $display("FAIL ff_clear: %0d bad (n=%0d) want 0 bad 168 writes", clear_errors(), wq.size()); end
    tests++; if (cur_col !== 5'd0 || cur_row !== 3'd0) begin fails++; $display("FAIL ff_cursor: got %0d,%0d want 0,0", cur_col, cur_row); end
  endtask

  task automatic test_reset_mid_clear;
    int lat, pre;
    wait_ready(5000);
    wq.delete();
    char_in = 8'h0C;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (300) @(negedge clk);
    tests++; if (busy !== 1'b1 || wq.size() == 0) begin fails++; $display("FAIL midclear_progress: busy %b writes %0d want busy 1 writes >0", busy, wq.size()); end
    rst = 1'b1;
    #1;
    tests++; if (wr !== 1'b0 || posx !== 7'd0 || posy !== 6'd0 || caracter !== 7'h20 || char_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL midclear_rst_vals: wr %b x %0d y %0d c %h rdy %b busy %b want 0 0 0 20 0 1", wr, posx, posy, caracter, char_ready, busy); end
    wq.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_ready(5000);
    tests++; if (clear_errors() != 0) begin fails++; $display("FAIL midclear_restart: %0d bad (n=%0d) want 0 bad 168 writes", clear_errors(), wq.size()); end
    tests++; if (cur_col !== 5'd0 || cur_row !== 3'd0) begin fails++; $display("FAIL midclear_cursor: got %0d,%0d want 0,0", cur_col, cur_row); end
    send_byte(8'h5A, lat, pre);
    tests++; if (wq[pre] !== {7'd0, 6'd0, 7'h5A} || lat != 19) begin fails++; $display("FAIL post_rst_print: got %h lat %0d want %h lat 19", wq[pre], lat, {7'd0, 6'd0, 7'h5A}); end
  endtask

  initial begin
    test_reset;
    test_print;
    test_row_wrap;
    test_line_feed;
    test_backspace;
    test_codes;
    test_form_feed;
    test_reset_mid_clear;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
